// File: rtl/rand_pkg.sv
// Shared definitions for the random-source sharing controller: state encoding,
// default seed, default widths and the rejection-sampling mask helper.
package rand_pkg;

   typedef enum logic [1:0] {
      ST_SEED = 2'd0,
      ST_IDLE = 2'd1,
      ST_DRAW = 2'd2
   } state_t;

   localparam logic [30:0] DEFAULT_SEED = 31'h44D5AFAB;
   localparam int          RAND_W_DEF   = 10;
   localparam int          VAL_W_DEF    = 3;

   // Smallest all-ones value (2**k-1) that is >= rng; rng=0 gives 0.
   function automatic logic [15:0] mask_for(input logic [15:0] rng);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) begin
         if (m < rng) m = {m[14:0], 1'b1};
      end
      return m;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request strictly after
// ptr (wrapping), returning a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx,
   output logic             any
);

   logic [IW-1:0] j;

   // Scan from farthest to nearest so the nearest set request wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         j = IW'((int'(ptr) + i) % N_REQ);
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = j;
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rand_share_ctrl.sv
// Seeds one LFSR generator and shares its output among N_REQ requesters with
// round-robin grants and rejection sampling. RAND_STATS_EN builds the reject counter.
module rand_share_ctrl
   import rand_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int RAND_W    = RAND_W_DEF,
   parameter int VAL_W     = VAL_W_DEF,
   parameter int MAX_TRIES = 8,
   parameter int SEED_CYC  = 2
) (
   input  logic                   qzt_clk,
   input  logic                   rst_n,
   input  logic [30:0]            seed_in,
   input  logic                   reseed,
   output logic                   gen_set,
   output logic [30:0]            gen_seed,
   input  logic [RAND_W-1:0]      rand_in,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*VAL_W-1:0] range_max,
   output logic [N_REQ-1:0]       ack,
   output logic [VAL_W-1:0]       rand_val,
   output logic                   busy,
   output logic [15:0]            reject_cnt,
   output state_t                 fsm_state
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state;
   logic [7:0]       seed_cnt;
   logic             reseed_pend;
   logic [30:0]      seed_hold;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    gnt_idx;
   logic [VAL_W-1:0] rng_q;
   logic [VAL_W-1:0] mask_q;
   logic [3:0]       tries;

   logic [N_REQ-1:0] arb_grant;
   logic [IW-1:0]    arb_idx;
   logic             arb_any;
   logic [VAL_W-1:0] arb_rng;
   logic [VAL_W-1:0] samp;
   logic             rejected;
   logic [VAL_W-1:0] fallback;
   logic [3:0]       tries_nxt;
   logic             rand_unused;

   rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign arb_rng     = range_max[arb_idx*VAL_W +: VAL_W];
   assign samp        = rand_in[VAL_W-1:0] & mask_q;
   assign rejected    = samp > rng_q;
   assign fallback    = samp - rng_q - VAL_W'(1);
   assign tries_nxt   = tries + 4'd1;
   assign rand_unused = ^{rand_in[RAND_W-1:VAL_W], arb_grant};
   assign fsm_state   = state;

   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_SEED;
         gen_set     <= 1'b1;
         gen_seed    <= DEFAULT_SEED;
         ack         <= '0;
         rand_val    <= '0;
         busy        <= 1'b1;
         rr_ptr      <= IW'(N_REQ - 1);
         seed_cnt    <= '0;
         reseed_pend <= 1'b0;
         seed_hold   <= DEFAULT_SEED;
         gnt_idx     <= '0;
         rng_q       <= '0;
         mask_q      <= '0;
         tries       <= '0;
      end else begin
         ack <= '0;
         if (reseed) begin
            reseed_pend <= 1'b1;
            seed_hold   <= seed_in;
         end
         case (state)
            ST_SEED: begin
               if (reseed) begin
                  gen_seed    <= seed_in;
                  seed_cnt    <= '0;
                  reseed_pend <= 1'b0;
               end else if (seed_cnt == 8'(SEED_CYC - 1)) begin
                  state    <= ST_IDLE;
                  gen_set  <= 1'b0;
                  busy     <= 1'b0;
                  seed_cnt <= '0;
               end else begin
                  seed_cnt <= seed_cnt + 8'd1;
               end
            end
            ST_IDLE: begin
               if (reseed_pend || reseed) begin
                  gen_seed    <= reseed ? seed_in : seed_hold;
                  reseed_pend <= 1'b0;
                  state       <= ST_SEED;
                  gen_set     <= 1'b1;
                  busy        <= 1'b1;
                  seed_cnt    <= '0;
               end else if (arb_any) begin
                  gnt_idx <= arb_idx;
                  rng_q   <= arb_rng;
                  mask_q  <= VAL_W'(mask_for(16'(arb_rng)));
                  tries   <= '0;
                  state   <= ST_DRAW;
                  busy    <= 1'b1;
               end
            end
            ST_DRAW: begin
               // A dropped request abandons the draw without touching rr_ptr.
               if (!req[gnt_idx]) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (!rejected || tries_nxt == 4'(MAX_TRIES)) begin
                  ack      <= N_REQ'(1) << gnt_idx;
                  rand_val <= rejected ? fallback : samp;
                  rr_ptr   <= gnt_idx;
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
               end else begin
                  tries <= tries_nxt;
               end
            end
            default: begin
               state <= ST_SEED;
               busy  <= 1'b1;
            end
         endcase
      end
   end

`ifdef RAND_STATS_EN
   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         reject_cnt <= '0;
      end else if (state == ST_DRAW && req[gnt_idx] && rejected && reject_cnt != 16'hFFFF) begin
         reject_cnt <= reject_cnt + 16'd1;
      end
   end
`else
   assign reject_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_rand_share_ctrl.sv
// Bench for rand_share_ctrl: directed and random draws against a behavioural
// model, with a queue of expected {ack, value} pairs checked by a monitor.
module tb_rand_share_ctrl;
   import rand_pkg::*;

   localparam int N_REQ     = 4;
   localparam int RAND_W    = 10;
   localparam int VAL_W     = 3;
   localparam int MAX_TRIES = 8;
   localparam int RW        = N_REQ * VAL_W;
   localparam int EW        = N_REQ + VAL_W;

   logic              qzt_clk;
   logic              rst_n;
   logic [30:0]       seed_in;
   logic              reseed;
   logic              gen_set;
   logic [30:0]       gen_seed;
   logic [RAND_W-1:0] rand_in;
   logic [N_REQ-1:0]  req;
   logic [RW-1:0]     range_max;
   logic [N_REQ-1:0]  ack;
   logic [VAL_W-1:0]  rand_val;
   logic              busy;
   logic [15:0]       reject_cnt;
   state_t            dut_state;

   int checks   = 0;
   int failures = 0;
   int exp_rej  = 0;
   int ptr_m    = N_REQ - 1;
   logic [EW-1:0]    exp_q[$];
   logic [VAL_W-1:0] smp_q[$];
   logic [EW-1:0]    mon_exp;

   rand_share_ctrl #(
      .N_REQ(N_REQ), .RAND_W(RAND_W), .VAL_W(VAL_W), .MAX_TRIES(MAX_TRIES), .SEED_CYC(2)
   ) dut (
      .qzt_clk    (qzt_clk),
      .rst_n      (rst_n),
      .seed_in    (seed_in),
      .reseed     (reseed),
      .gen_set    (gen_set),
      .gen_seed   (gen_seed),
      .rand_in    (rand_in),
      .req        (req),
      .range_max  (range_max),
      .ack        (ack),
      .rand_val   (rand_val),
      .busy       (busy),
      .reject_cnt (reject_cnt),
      .fsm_state  (dut_state)
   );

   // ---------------- clock ----------------
   initial begin
      qzt_clk = 1'b0;
      forever #5 qzt_clk = ~qzt_clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_rej();
`ifdef RAND_STATS_EN
      chk("reject_cnt", 32'(reject_cnt), 32'(exp_rej));
`else
      chk("reject_cnt", 32'(reject_cnt), 32'd0);
`endif
   endtask

   // Round-robin reference: first requester after the last granted one.
   function automatic int rr_next(input logic [N_REQ-1:0] r, input int p);
      for (int i = 1; i <= N_REQ; i++) begin
         if (r[(p + i) % N_REQ]) return (p + i) % N_REQ;
      end
      return -1;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge qzt_clk) begin
      if (rst_n && ack != '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=%b required=none", ack);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("ack_val", 32'({ack, rand_val}), 32'(mon_exp));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n = 1'b0; req = '0; reseed = 1'b0; rand_in = '0; range_max = '0; seed_in = '0;
      repeat (2) @(negedge qzt_clk);
      chk("rst_gen_set", 32'(gen_set), 32'd1);
      chk("rst_gen_seed", 32'(gen_seed), 32'h44D5AFAB);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_rand_val", 32'(rand_val), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_reject_cnt", 32'(reject_cnt), 32'd0);
      exp_rej = 0;
      ptr_m   = N_REQ - 1;
      rst_n   = 1'b1;
      @(negedge qzt_clk);
      chk("seed_cyc1_gen_set", 32'(gen_set), 32'd1);
      chk("seed_cyc1_busy", 32'(busy), 32'd1);
      @(negedge qzt_clk);
      chk("seed_done_gen_set", 32'(gen_set), 32'd0);
      chk("seed_done_busy", 32'(busy), 32'd0);
   endtask

   // One draw by a lone requester; samples come from smp_q, else random.
   task automatic draw(input int idx, input int r, input int reseed_at);
      logic [VAL_W-1:0] samp[MAX_TRIES];
      logic [N_REQ-1:0] oh;
      logic [RW-1:0]    rm;
      int n, mask, m, v, dcyc;
      mask = (1 << $clog2(r + 1)) - 1;
      n = 0;
      v = 0;
      for (int t = 0; t < MAX_TRIES && n == 0; t++) begin
         samp[t] = (smp_q.size() > 0) ? smp_q.pop_front() : VAL_W'($urandom_range(0, 7));
         m = int'(samp[t]) & mask;
         if (m <= r) begin
            v = m;
            n = t + 1;
         end else begin
            exp_rej++;
            if (t == MAX_TRIES - 1) begin
               v = m - (r + 1);
               n = MAX_TRIES;
            end
         end
      end
      oh = N_REQ'(1) << idx;
      exp_q.push_back({oh, VAL_W'(v)});
      rm = RW'($urandom);
      rm[idx*VAL_W +: VAL_W] = VAL_W'(r);
      req = oh;
      range_max = rm;
      rand_in = RAND_W'($urandom);
      @(posedge qzt_clk);
      dcyc = 0;
      for (int t = 0; t < n; t++) begin
         @(negedge qzt_clk);
         if (busy) dcyc++;
         if (t == 0) range_max = RW'($urandom);
         rand_in = RAND_W'($urandom);
         rand_in[VAL_W-1:0] = samp[t];
         if (t == reseed_at) begin
            reseed  = 1'b1;
            seed_in = 31'h1;
         end else begin
            reseed = 1'b0;
         end
         @(posedge qzt_clk);
      end
      @(negedge qzt_clk);
      reseed = 1'b0;
      chk("draw_cycles", 32'(dcyc), 32'(n));
      chk("ack_timing", 32'(ack), 32'(oh));
      req = '0;
      ptr_m = idx;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();

      smp_q = '{3'd3};
      draw(0, 5, -1);
      chk_rej();

      smp_q = '{3'd6, 3'd7, 3'd5, 3'd2};
      draw(0, 4, -1);
      chk_rej();

      for (int i = 0; i < MAX_TRIES; i++) smp_q.push_back(3'd7);
      draw(0, 4, -1);
      chk_rej();

      repeat (40) draw($urandom_range(0, N_REQ - 1), $urandom_range(0, 7), -1);
      chk_rej();

      // Reseed mid-draw: the draw finishes, then seeding runs with the new seed.
      smp_q = '{3'd7, 3'd7, 3'd2};
      draw(1, 4, 1);
      @(posedge qzt_clk);
      @(negedge qzt_clk);
      chk("reseed_gen_set1", 32'(gen_set), 32'd1);
      chk("reseed_gen_seed", 32'(gen_seed), 32'd1);
      chk("reseed_busy", 32'(busy), 32'd1);
      @(negedge qzt_clk);
      chk("reseed_gen_set2", 32'(gen_set), 32'd1);
      @(negedge qzt_clk);
      chk("reseed_gen_set3", 32'(gen_set), 32'd0);
      chk("reseed_busy_done", 32'(busy), 32'd0);
      draw(3, 2, -1);
      chk_rej();

      // Reset in the middle of a draw: no ack, immediate reset values.
      req = 4'b0010;
      range_max = '0;
      range_max[VAL_W +: VAL_W] = 3'd4;
      rand_in = RAND_W'(7);
      @(posedge qzt_clk);
      @(negedge qzt_clk);
      @(posedge qzt_clk);
      @(negedge qzt_clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(ack), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd1);
      chk("mid_rst_gen_set", 32'(gen_set), 32'd1);
      chk("mid_rst_gen_seed", 32'(gen_seed), 32'h44D5AFAB);
      chk("mid_rst_reject_cnt", 32'(reject_cnt), 32'd0);
      do_reset();

      // Aborted draw: no ack, back to IDLE, pointer unchanged.
      req = 4'b0100;
      range_max = '0;
      range_max[2*VAL_W +: VAL_W] = 3'd4;
      rand_in = RAND_W'(7);
      @(posedge qzt_clk);
      @(negedge qzt_clk);
      @(posedge qzt_clk);
      exp_rej++;
      @(negedge qzt_clk);
      req = '0;
      rand_in = '0;
      @(posedge qzt_clk);
      @(negedge qzt_clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_state", 32'(dut_state), 32'(ST_IDLE));
      chk_rej();

      // All requesters held, each drops for one cycle after its ack.
      range_max = '1;
      req = '1;
      for (int k = 0; k < 5; k++) begin
         int g;
         logic [VAL_W-1:0] v;
         logic [N_REQ-1:0] oh;
         g  = rr_next(req, ptr_m);
         oh = N_REQ'(1) << g;
         v  = VAL_W'($urandom_range(0, 7));
         rand_in = RAND_W'($urandom);
         rand_in[VAL_W-1:0] = v;
         exp_q.push_back({oh, v});
         @(posedge qzt_clk);
         @(negedge qzt_clk);
         req = '1;
         @(posedge qzt_clk);
         @(negedge qzt_clk);
         chk("rr_grant", 32'(ack), 32'(oh));
         ptr_m = g;
         req = '1 & ~oh;
      end
      req = '0;

      repeat (3) @(negedge qzt_clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
